// File: rtl/pll_lock_sequencer_if.sv
// Signal bundle between the PLL lock sequencer and its environment.
// Lock-loss counter signals exist only when PLL_SEQ_LOSS_CNT_EN is defined.
interface pll_lock_sequencer_if #(
  parameter int NUM_DOMAINS = 4
);
  logic                   restart;
  logic                   pll_locked;
  logic                   pll_rst;
  logic [NUM_DOMAINS-1:0] domain_rst_n;
  logic                   ready;
  logic                   fail;
  logic [3:0]             retry_cnt;
  logic [2:0]             state;
`ifdef PLL_SEQ_LOSS_CNT_EN
  logic [7:0]             lock_loss_cnt;
  logic                   lock_loss_evt;
`endif

  modport master (
    output restart,
    output pll_locked,
    input  pll_rst,
    input  domain_rst_n,
    input  ready,
    input  fail,
    input  retry_cnt,
    input  state
`ifdef PLL_SEQ_LOSS_CNT_EN
    ,
    input  lock_loss_cnt,
    input  lock_loss_evt
`endif
  );

  modport slave (
    input  restart,
    input  pll_locked,
    output pll_rst,
    output domain_rst_n,
    output ready,
    output fail,
    output retry_cnt,
    output state
`ifdef PLL_SEQ_LOSS_CNT_EN
    ,
    output lock_loss_cnt,
    output lock_loss_evt
`endif
  );
endinterface

// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock qualification and staggered domain reset release.
// Optional lock-loss counter enabled by defining PLL_SEQ_LOSS_CNT_EN.
module pll_lock_sequencer #(
  parameter int NUM_DOMAINS    = 4,
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 65536,
  parameter int STABLE_CYCLES  = 1024,
  parameter int STAGGER_CYCLES = 8,
  parameter int MAX_RETRIES    = 3
) (
  input logic                 refclk,
  input logic                 rst_n,
  pll_lock_sequencer_if.slave bus
);
  localparam int M1 = (PLL_RST_CYCLES > LOCK_TIMEOUT) ?
                      PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int M2 = (STABLE_CYCLES > STAGGER_CYCLES) ?
                      STABLE_CYCLES : STAGGER_CYCLES;
  localparam int MC = (M1 > M2) ? M1 : M2;
  localparam int CW = (MC > 1) ? $clog2(MC) : 1;

  localparam logic [CW-1:0] RST_END  = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] TMO_END  = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STAB_END = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] STAG_END = CW'(STAGGER_CYCLES - 1);
  localparam logic [3:0]    RETRY_MX = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_RESET_PLL = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RELEASE   = 3'd3,
    S_RUN       = 3'd4,
    S_FAIL      = 3'd5
  } state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [3:0]             retry_q, retry_d;
  logic [NUM_DOMAINS-1:0] dom_q, dom_d;
  logic                   sync1_q, sync2_q;
  logic                   pll_rst_q, ready_q, fail_q;
  logic                   locked_s;
  logic                   loss;

  assign locked_s = sync2_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    dom_d   = dom_q;
    loss    = 1'b0;
    if (bus.restart) begin
      state_d = S_RESET_PLL;
      cnt_d   = '0;
      retry_d = '0;
      dom_d   = '0;
    end else begin
      unique case (state_q)
        S_RESET_PLL: begin
          if (cnt_q == RST_END) begin
            state_d = S_WAIT_LOCK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_WAIT_LOCK: begin
          // a lock seen on the timeout cycle still counts
          if (locked_s) begin
            state_d = S_STABLE;
            cnt_d   = '0;
          end else if (cnt_q == TMO_END) begin
            cnt_d = '0;
            if (retry_q == RETRY_MX) begin
              state_d = S_FAIL;
            end else begin
              state_d = S_RESET_PLL;
              retry_d = retry_q + 4'd1;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_STABLE: begin
          if (!locked_s) begin
            state_d = S_WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == STAB_END) begin
            state_d = S_RELEASE;
            cnt_d   = '0;
            dom_d   = NUM_DOMAINS'(1);
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_RELEASE: begin
          // domain releases form a thermometer code, lsb first
          if (!locked_s) begin
            loss = 1'b1;
          end else if (dom_q[NUM_DOMAINS-1]) begin
            state_d = S_RUN;
            cnt_d   = '0;
            retry_d = '0;
          end else if (cnt_q == STAG_END) begin
            cnt_d = '0;
            dom_d = (dom_q << 1) | NUM_DOMAINS'(1);
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_RUN:   loss = !locked_s;
        S_FAIL:  state_d = S_FAIL;
        default: state_d = S_RESET_PLL;
      endcase
      if (loss) begin
        state_d = S_RESET_PLL;
        cnt_d   = '0;
        dom_d   = '0;
      end
    end
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      state_q   <= S_RESET_PLL;
      cnt_q     <= '0;
      retry_q   <= '0;
      dom_q     <= '0;
      pll_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      sync1_q   <= bus.pll_locked;
      sync2_q   <= sync1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      dom_q     <= dom_d;
      pll_rst_q <= (state_d == S_RESET_PLL) ||
                   (state_d == S_FAIL);
      ready_q   <= (state_d == S_RUN);
      fail_q    <= (state_d == S_FAIL);
    end
  end

  assign bus.pll_rst      = pll_rst_q;
  assign bus.domain_rst_n = dom_q;
  assign bus.ready        = ready_q;
  assign bus.fail         = fail_q;
  assign bus.retry_cnt    = retry_q;
  assign bus.state        = state_q;

`ifdef PLL_SEQ_LOSS_CNT_EN
  logic [7:0] loss_cnt_q;
  logic       loss_evt_q;

  // survives restart; only rst_n clears it
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      loss_cnt_q <= '0;
      loss_evt_q <= 1'b0;
    end else begin
      loss_evt_q <= loss;
      if (loss && (loss_cnt_q != 8'hFF)) begin
        loss_cnt_q <= loss_cnt_q + 8'd1;
      end
    end
  end

  assign bus.lock_loss_cnt = loss_cnt_q;
  assign bus.lock_loss_evt = loss_evt_q;
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Bench for pll_lock_sequencer: directed scenarios plus random lock
// activity, checked against a time-based reference model.
module tb_pll_lock_sequencer;
  localparam int ND  = 4;
  localparam int PRC = 4;
  localparam int LT  = 32;
  localparam int SC  = 8;
  localparam int ST  = 2;
  localparam int MR  = 2;
  localparam logic [13:0] RST_V = 14'b1_0000_0_0_0000_000;

  logic refclk = 1'b0;
  logic rst_n  = 1'b1;
  int   total  = 0;
  int   bad    = 0;

  pll_lock_sequencer_if #(.NUM_DOMAINS(ND)) bus ();

  pll_lock_sequencer #(
    .NUM_DOMAINS   (ND),
    .PLL_RST_CYCLES(PRC),
    .LOCK_TIMEOUT  (LT),
    .STABLE_CYCLES (SC),
    .STAGGER_CYCLES(ST),
    .MAX_RETRIES   (MR)
  ) dut (
    .refclk(refclk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 refclk = ~refclk;

  // reference model: phase + time spent in phase
  int   m_ph = 0;
  int   m_t  = 0;
  int   m_r  = 0;
  int   m_lc = 0;
  logic m_h1 = 1'b0;
  logic m_h2 = 1'b0;
  logic m_ls = 1'b0;
  logic m_ev = 1'b0;

  always @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      m_ph = 0; m_t = 0; m_r = 0; m_lc = 0;
      m_h1 = 0; m_h2 = 0; m_ev = 0;
    end else begin
      m_ls = m_h2;
      m_h2 = m_h1;
      m_h1 = bus.pll_locked;
      m_ev = 1'b0;
      if (bus.restart) begin
        m_ph = 0; m_t = 0; m_r = 0;
      end else begin
        case (m_ph)
          0: begin
            m_t++;
            if (m_t == PRC) begin m_ph = 1; m_t = 0; end
          end
          1: begin
            if (m_ls) begin
              m_ph = 2; m_t = 0;
            end else begin
              m_t++;
              if (m_t == LT) begin
                m_t = 0;
                if (m_r == MR) m_ph = 5;
                else begin m_ph = 0; m_r++; end
              end
            end
          end
          2: begin
            if (!m_ls) begin
              m_ph = 1; m_t = 0;
            end else begin
              m_t++;
              if (m_t == SC) begin m_ph = 3; m_t = 0; end
            end
          end
          3, 4: begin
            if (!m_ls) begin
              m_ph = 0; m_t = 0; m_ev = 1'b1;
              if (m_lc < 255) m_lc++;
            end else if (m_ph == 3) begin
              if (m_t == (ND - 1) * ST) begin
                m_ph = 4; m_t = 0; m_r = 0;
              end else m_t++;
            end
          end
          default: ;
        endcase
      end
    end
  end

  function automatic logic [13:0] model_vec();
    logic [3:0] d;
    int n;
    d = 4'h0;
    if (m_ph == 3) begin
      n = m_t / ST + 1;
      if (n > ND) n = ND;
      d = 4'((1 << n) - 1);
    end else if (m_ph == 4) begin
      d = 4'hF;
    end
    return {(m_ph == 0 || m_ph == 5), d, (m_ph == 4),
            (m_ph == 5), 4'(m_r), 3'(m_ph)};
  endfunction

  function automatic logic [13:0] dut_vec();
    return {bus.pll_rst, bus.domain_rst_n, bus.ready,
            bus.fail, bus.retry_cnt, bus.state};
  endfunction

  task automatic test_reset();
    #2 rst_n = 1'b0;
    repeat (3) @(negedge refclk);
    total++;
    if (dut_vec() !== RST_V) begin
      bad++;
      $display("FAIL reset got=%h exp=%h", dut_vec(), RST_V);
    end
    total++;
    if (dut_vec() !== model_vec()) begin
      bad++;
      $display("FAIL reset_model got=%h exp=%h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_nominal();
    int hi;
    int rdy_at;
    rst_n = 1'b1;
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.pll_rst !== 1'b1) break;
      hi++;
      @(negedge refclk);
      total++;
      if (dut_vec() !== model_vec()) begin
        bad++;
        $display("FAIL nom_rst got=%h exp=%h", dut_vec(), model_vec());
      end
    end
    total++;
    if (hi != PRC) begin
      bad++;
      $display("FAIL pll_rst_width got=%0d exp=%0d", hi, PRC);
    end
    repeat (10) begin
      @(negedge refclk);
      total++;
      if (dut_vec() !== model_vec()) begin
        bad++;
        $display("FAIL nom_wait got=%h exp=%h", dut_vec(), model_vec());
      end
    end
    bus.pll_locked = 1'b1;
    rdy_at = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge refclk);
      total++;
      if (dut_vec() !== model_vec()) begin
        bad++;
        $display("FAIL nom_seq k=%0d got=%h exp=%h",
                 k, dut_vec(), model_vec());
      end
      if (k == 11) begin
        total++;
        if (bus.domain_rst_n !== 4'b0001) begin
          bad++;
          $display("FAIL first_release got=%b exp=0001", bus.domain_rst_n);
        end
      end
      if (k == 17) begin
        total++;
        if (bus.domain_rst_n !== 4'b1111 || bus.ready !== 1'b0) begin
          bad++;
          $display("FAIL last_release got=%b/%b exp=1111/0",
                   bus.domain_rst_n, bus.ready);
        end
      end
      if (bus.ready === 1'b1) begin
        rdy_at = k;
        break;
      end
    end
    total++;
    if (rdy_at != 18) begin
      bad++;
      $display("FAIL ready_latency got=%0d exp=18", rdy_at);
    end
  endtask

  task automatic test_glitch();
    int run;
    bit rel;
    bus.restart = 1'b1;
    @(negedge refclk);
    bus.restart = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge refclk);
      total++;
      if (dut_vec() !== model_vec()) begin
        bad++;
        $display("FAIL gl_pre got=%h exp=%h", dut_vec(), model_vec());
      end
      if (bus.state === 3'd2) break;
    end
    repeat (4) begin
      @(negedge refclk);
      total++;
      if (dut_vec() !== model_vec()) begin
        bad++;
        $display("FAIL gl_stab got=%h exp=%h", dut_vec(), model_vec());
      end
    end
    bus.pll_locked = 1'b0;
    @(negedge refclk);
    bus.pll_locked = 1'b1;
    run = 0;
    rel = 0;
    for (int i = 0; i < 60 && !rel; i++) begin
      @(negedge refclk);
      total++;
      if (dut_vec() !== model_vec()) begin
        bad++;
        $display("FAIL gl_seq got=%h exp=%h", dut_vec(), model_vec());
      end
      if (bus.state === 3'd2) run++;
      else if (bus.state === 3'd3) rel = 1;
      else begin
        run = 0;
        total++;
        if (bus.domain_rst_n !== 4'b0000) begin
          bad++;
          $display("FAIL gl_dom got=%b exp=0000", bus.domain_rst_n);
        end
      end
    end
    total++;
    if (!rel || run != SC) begin
      bad++;
      $display("FAIL gl_fresh got=%0d rel=%0d exp=%0d", run, rel, SC);
    end
  endtask

  task automatic test_timeout();
    int  w;
    bit  saw1;
    bus.pll_locked = 1'b0;
    bus.restart = 1'b1;
    @(negedge refclk);
    bus.restart = 1'b0;
    w = 0;
    saw1 = 0;
    for (int i = 0; i < 115; i++) begin
      @(negedge refclk);
      total++;
      if (dut_vec() !== model_vec()) begin
        bad++;
        $display("FAIL to_seq got=%h exp=%h", dut_vec(), model_vec());
      end
      if (bus.state === 3'd1) w++;
      if (bus.retry_cnt === 4'd1) saw1 = 1;
    end
    total++;
    if (w != 3 * LT || !saw1) begin
      bad++;
      $display("FAIL to_windows got=%0d/%0d exp=%0d/1", w, saw1, 3 * LT);
    end
    total++;
    if ({bus.fail, bus.pll_rst, bus.retry_cnt, bus.state} !==
        {2'b11, 4'd2, 3'd5}) begin
      bad++;
      $display("FAIL to_fail got=%b%b/%0d/%0d exp=11/2/5",
               bus.fail, bus.pll_rst, bus.retry_cnt, bus.state);
    end
    bus.restart = 1'b1;
    @(negedge refclk);
    bus.restart = 1'b0;
    total++;
    if ({bus.fail, bus.retry_cnt, bus.state} !== 8'h0) begin
      bad++;
      $display("FAIL to_restart got=%b/%0d/%0d exp=0/0/0",
               bus.fail, bus.retry_cnt, bus.state);
    end
  endtask

  task automatic test_runloss();
    bit rdy;
    int ev;
    bus.pll_locked = 1'b1;
    rdy = 0;
    for (int i = 0; i < 100 && !rdy; i++) begin
      @(negedge refclk);
      total++;
      if (dut_vec() !== model_vec()) begin
        bad++;
        $display("FAIL rl_up got=%h exp=%h", dut_vec(), model_vec());
      end
      rdy = (bus.ready === 1'b1);
    end
    total++;
    if (!rdy) begin
      bad++;
      $display("FAIL rl_ready got=0 exp=1");
    end
    repeat (5) @(negedge refclk);
    bus.pll_locked = 1'b0;
    ev = 0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge refclk);
`ifdef PLL_SEQ_LOSS_CNT_EN
      if (bus.lock_loss_evt === 1'b1) ev++;
`endif
      total++;
      if (i < 3 && bus.ready !== 1'b1) begin
        bad++;
        $display("FAIL rl_early i=%0d got=%b exp=1", i, bus.ready);
      end
      if (i == 3 && {bus.domain_rst_n, bus.ready, bus.pll_rst,
                     bus.state} !== 9'b0000_0_1_000) begin
        bad++;
        $display("FAIL rl_drop got=%b/%b/%b/%0d exp=0000/0/1/0",
                 bus.domain_rst_n, bus.ready, bus.pll_rst, bus.state);
      end
    end
    bus.pll_locked = 1'b1;
    rdy = 0;
    for (int i = 0; i < 100 && !rdy; i++) begin
      @(negedge refclk);
`ifdef PLL_SEQ_LOSS_CNT_EN
      if (bus.lock_loss_evt === 1'b1) ev++;
`endif
      total++;
      if (dut_vec() !== model_vec()) begin
        bad++;
        $display("FAIL rl_reseq got=%h exp=%h", dut_vec(), model_vec());
      end
      rdy = (bus.ready === 1'b1);
    end
    total++;
    if (!rdy) begin
      bad++;
      $display("FAIL rl_reready got=0 exp=1");
    end
`ifdef PLL_SEQ_LOSS_CNT_EN
    total++;
    if (bus.lock_loss_cnt !== 8'd1 || ev != 1) begin
      bad++;
      $display("FAIL rl_losscnt got=%0d/%0d exp=1/1",
               bus.lock_loss_cnt, ev);
    end
`endif
  endtask

  task automatic test_restart_release();
    bit hit;
    bus.restart = 1'b1;
    @(negedge refclk);
    bus.restart = 1'b0;
    hit = 0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge refclk);
      total++;
      if (dut_vec() !== model_vec()) begin
        bad++;
        $display("FAIL rr_seq got=%h exp=%h", dut_vec(), model_vec());
      end
      hit = (bus.domain_rst_n === 4'b0011);
    end
    bus.restart = 1'b1;
    @(negedge refclk);
    bus.restart = 1'b0;
    total++;
    if (!hit || {bus.domain_rst_n, bus.pll_rst, bus.state} !==
        8'b0000_1_000) begin
      bad++;
      $display("FAIL rr_restart got=%0d:%b/%b/%0d exp=1:0000/1/0",
               hit, bus.domain_rst_n, bus.pll_rst, bus.state);
    end
  endtask

  task automatic test_async_reset();
    bit rdy;
    rdy = 0;
    for (int i = 0; i < 100 && !rdy; i++) begin
      @(negedge refclk);
      rdy = (bus.ready === 1'b1);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (!rdy || dut_vec() !== RST_V) begin
      bad++;
      $display("FAIL async_rst got=%0d:%h exp=1:%h", rdy, dut_vec(), RST_V);
    end
`ifdef PLL_SEQ_LOSS_CNT_EN
    total++;
    if (bus.lock_loss_cnt !== 8'd0) begin
      bad++;
      $display("FAIL async_losscnt got=%0d exp=0", bus.lock_loss_cnt);
    end
`endif
    @(negedge refclk);
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    int runs;
    runs = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge refclk);
      total++;
      if (dut_vec() !== model_vec()) begin
        bad++;
        $display("FAIL rnd i=%0d got=%h exp=%h", i, dut_vec(), model_vec());
      end
`ifdef PLL_SEQ_LOSS_CNT_EN
      total++;
      if (bus.lock_loss_cnt !== 8'(m_lc) || bus.lock_loss_evt !== m_ev) begin
        bad++;
        $display("FAIL rnd_loss i=%0d got=%0d/%b exp=%0d/%b",
                 i, bus.lock_loss_cnt, bus.lock_loss_evt, m_lc, m_ev);
      end
`endif
      if (bus.ready === 1'b1) runs++;
      if ($urandom_range(0, 39) == 0) bus.pll_locked = ~bus.pll_locked;
      bus.restart = ($urandom_range(0, 299) == 0);
    end
    bus.restart = 1'b0;
    total++;
    if (runs == 0) begin
      bad++;
      $display("FAIL rnd_coverage got=0 exp=>0");
    end
  endtask

  initial begin
    bus.restart    = 1'b0;
    bus.pll_locked = 1'b0;
    test_reset();
    test_nominal();
    test_glitch();
    test_timeout();
    test_runloss();
    test_restart_release();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
